// File: rtl/vram_arbiter.sv
// ============================================================================
// Module   : vram_arbiter
// Purpose  : Shares one single-port synchronous VRAM between the display
//            fetch path (1 bpp, 8 pixels per word) and a CPU. The display
//            always wins the port; the CPU is deferred around display slots.
// Options  : define VRAM_ARB_CPU_READ_EN to enable CPU reads; without it every
//            CPU access is a write and cpu_rdata_o is tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vram_arbiter #(
  parameter int FRAME_WORDS = 38400,
  parameter int ADDR_W      = 16
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              rgb_en_i,
  input  logic              frame_start_i,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [7:0]        cpu_wdata_i,
  output logic              cpu_ack_o,
  output logic [7:0]        cpu_rdata_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_we_o,
  output logic [7:0]        mem_wdata_o,
  input  logic [7:0]        mem_rdata_i,
  output logic              pixel_o
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_WORDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_e;

  state_e            state_q;
  logic              ack_q;
  logic [ADDR_W-1:0] disp_addr_q, disp_addr_d;
  logic [2:0]        phase_q, phase_d;
  logic [7:0]        hb_q;
  logic [7:0]        sr_q, sr_d;
  logic              pixel_q, pixel_d;
  logic              slot_q;
  logic              slot;
  logic              issue;
  logic              cpu_we_eff;

  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
    return (a == LAST_ADDR) ? '0 : a + ADDR_W'(1);
  endfunction

`ifdef VRAM_ARB_CPU_READ_EN
  logic [7:0] rdata_q;
  assign cpu_we_eff  = cpu_we_i;
  assign cpu_rdata_o = rdata_q;

  // Read data arrives in WAIT; latch it for presentation during ACK
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rdata_q <= 8'd0;
    end else if (state_q == ST_WAIT && !cpu_we_i) begin
      rdata_q <= mem_rdata_i;
    end
  end
`else
  logic unused_cpu_we;
  assign unused_cpu_we = cpu_we_i;
  assign cpu_we_eff    = 1'b1;
  assign cpu_rdata_o   = 8'd0;
`endif

  // Display slot: frame prefetch, or the phase-1 fetch of the next word
  assign slot  = frame_start_i | (rgb_en_i & (phase_q == 3'd1));
  assign issue = ~reset_i & (state_q == ST_IDLE) & cpu_req_i & ~slot;

  assign cpu_ack_o = ack_q;
  assign pixel_o   = pixel_q;

  // Memory port mux (display first, then CPU issue) and display next-state
  always_comb begin
    mem_addr_o  = '0;
    mem_we_o    = 1'b0;
    mem_wdata_o = 8'd0;
    disp_addr_d = disp_addr_q;
    phase_d     = phase_q;
    sr_d        = sr_q;
    pixel_d     = 1'b0;
    if (!reset_i) begin
      if (frame_start_i) begin
        mem_addr_o = '0;
      end else if (slot) begin
        mem_addr_o = disp_addr_q;
      end else if (issue) begin
        mem_addr_o  = cpu_addr_i;
        mem_we_o    = cpu_we_eff;
        mem_wdata_o = cpu_wdata_i;
      end
    end
    if (frame_start_i) begin
      disp_addr_d = next_addr('0);
      phase_d     = 3'd0;
    end else if (slot) begin
      disp_addr_d = next_addr(disp_addr_q);
    end
    if (rgb_en_i) begin
      if (!frame_start_i) phase_d = phase_q + 3'd1;
      if (phase_q == 3'd0) begin
        pixel_d = hb_q[7];
        sr_d    = {hb_q[6:0], 1'b0};
      end else begin
        pixel_d = sr_q[7];
        sr_d    = {sr_q[6:0], 1'b0};
      end
    end
  end

  // Display pipeline registers: address, phase, hold buffer, shifter, pixel
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      disp_addr_q <= '0;
      phase_q     <= 3'd0;
      hb_q        <= 8'd0;
      sr_q        <= 8'd0;
      pixel_q     <= 1'b0;
      slot_q      <= 1'b0;
    end else begin
      disp_addr_q <= disp_addr_d;
      phase_q     <= phase_d;
      sr_q        <= sr_d;
      pixel_q     <= pixel_d;
      slot_q      <= slot;
      if (slot_q) hb_q <= mem_rdata_i;
    end
  end

  // CPU access FSM: issue in IDLE, data returns in WAIT, one-cycle ACK
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      ack_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          ack_q <= 1'b0;
          if (issue) state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          ack_q   <= 1'b1;
          state_q <= ST_ACK;
        end
        ST_ACK: begin
          ack_q   <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          ack_q   <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_vram_arbiter.sv
// ============================================================================
// Module   : tb_vram_arbiter
// Purpose  : Self-checking bench for vram_arbiter with a behavioural VRAM,
//            a pixel scoreboard and a CPU-acknowledge scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vram_arbiter;

  localparam int FW     = 12;
  localparam int ADDR_W = 16;
`ifdef VRAM_ARB_CPU_READ_EN
  localparam bit READ_EN = 1'b1;
`else
  localparam bit READ_EN = 1'b0;
`endif

  logic              clk;
  logic              rst;
  logic              rgb_en;
  logic              frame_start;
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [7:0]        cpu_wdata;
  logic              cpu_ack;
  logic [7:0]        cpu_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;
  logic              pixel;

  logic [7:0] vram [0:65535];
  logic       rgb_d;
  logic       mon_en;
  int         n_tests;
  int         n_fail;
  logic       pix_q [$];
  logic [7:0] rd_q  [$];

  vram_arbiter #(.FRAME_WORDS(FW), .ADDR_W(ADDR_W)) dut (
    .clk_i        (clk),
    .reset_i      (rst),
    .rgb_en_i     (rgb_en),
    .frame_start_i(frame_start),
    .cpu_req_i    (cpu_req),
    .cpu_we_i     (cpu_we),
    .cpu_addr_i   (cpu_addr),
    .cpu_wdata_i  (cpu_wdata),
    .cpu_ack_o    (cpu_ack),
    .cpu_rdata_o  (cpu_rdata),
    .mem_addr_o   (mem_addr),
    .mem_we_o     (mem_we),
    .mem_wdata_o  (mem_wdata),
    .mem_rdata_i  (mem_rdata),
    .pixel_o      (pixel)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous single-port VRAM, read-first
  always @(posedge clk) begin
    if (mem_we) vram[mem_addr] <= mem_wdata;
    mem_rdata <= vram[mem_addr];
  end

  always @(posedge clk) rgb_d <= rgb_en;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  // Pixel scoreboard: one expected bit per RGB_EN cycle, seen one cycle later
  always @(negedge clk) begin
    if (mon_en) begin
      if (!rgb_d) check_eq("pixel_idle", {31'd0, pixel}, 32'd0);
      else if (pix_q.size() > 0) check_eq("pixel", {31'd0, pixel}, {31'd0, pix_q.pop_front()});
    end
  end

  // CPU scoreboard: every ack must match a queued expected read value
  always @(negedge clk) begin
    if (mon_en && cpu_ack) begin
      if (rd_q.size() == 0) check_eq("ack_unexpected", 32'd1, 32'd0);
      else check_eq("ack_rdata", {24'd0, cpu_rdata}, {24'd0, rd_q.pop_front()});
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] pat;
    logic [7:0]  last_rd;
    int          k;
    n_tests = 0;
    n_fail  = 0;
    mon_en  = 1'b0;
    rgb_d   = 1'b0;
    for (int i = 0; i < 65536; i++) vram[i] = 8'd0;
    vram[0]   = 8'hA5;
    vram[1]   = 8'h0F;
    vram[100] = 8'h77;

    // Reset with busy inputs: port must stay quiet
    rst = 1'b1; rgb_en = 1'b0; frame_start = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'd55; cpu_wdata = 8'hAA;
    next();
    next();
    @(negedge clk);
    check_eq("rst_mem_we",   {31'd0, mem_we}, 32'd0);
    check_eq("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
    check_eq("rst_ack",      {31'd0, cpu_ack}, 32'd0);
    check_eq("rst_pixel",    {31'd0, pixel}, 32'd0);
    check_eq("rst_rdata",    {24'd0, cpu_rdata}, 32'd0);
    next();
    rst = 1'b0; frame_start = 1'b0; cpu_req = 1'b0;
    mon_en = 1'b1;

    // RGB_EN before any frame prefetch: pixel stays dark
    for (int i = 0; i < 8; i++) begin
      rgb_en = 1'b1;
      pix_q.push_back(1'b0);
      next();
    end
    rgb_en = 1'b0;
    next();
    next();

    // Frame fill: A5 then 0F shifted out MSB first
    frame_start = 1'b1;
    @(negedge clk);
    check_eq("fs_addr", {16'd0, mem_addr}, 32'd0);
    check_eq("fs_we",   {31'd0, mem_we}, 32'd0);
    next();
    frame_start = 1'b0;
    next();
    next();
    next();
    pat = 16'hA50F;
    for (int i = 0; i < 16; i++) begin
      rgb_en = 1'b1;
      pix_q.push_back(pat[15 - i]);
      if (i == 1) begin
        @(negedge clk);
        check_eq("fill_slot_addr", {16'd0, mem_addr}, 32'd1);
      end
      next();
    end
    rgb_en = 1'b0;
    next();
    next();

    // Contention: CPU request lands on a display slot and is deferred
    rgb_en = 1'b1;
    next();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'd5; cpu_wdata = 8'h3C;
    rd_q.push_back(8'h00);
    @(negedge clk);
    check_eq("cont_slot_addr", {16'd0, mem_addr}, 32'd3);
    check_eq("cont_slot_we",   {31'd0, mem_we}, 32'd0);
    next();
    @(negedge clk);
    check_eq("cont_issue_we",    {31'd0, mem_we}, 32'd1);
    check_eq("cont_issue_addr",  {16'd0, mem_addr}, 32'd5);
    check_eq("cont_issue_wdata", {24'd0, mem_wdata}, 32'h3C);
    check_eq("cont_ack_wait",    {31'd0, cpu_ack}, 32'd0);
    next();
    @(negedge clk);
    check_eq("cont_ack_early", {31'd0, cpu_ack}, 32'd0);
    next();
    @(negedge clk);
    check_eq("cont_ack", {31'd0, cpu_ack}, 32'd1);
    next();
    cpu_req = 1'b0;
    next();
    next();
    rgb_en = 1'b0;
    next();
    check_eq("cont_vram5", {24'd0, vram[5]}, 32'h3C);

    // CPU read of address 100 while idle
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'd100; cpu_wdata = 8'h5A;
    last_rd = READ_EN ? 8'h77 : 8'h00;
    rd_q.push_back(last_rd);
    @(negedge clk);
    check_eq("rd_issue_addr", {16'd0, mem_addr}, 32'd100);
    check_eq("rd_issue_we",   {31'd0, mem_we}, READ_EN ? 32'd0 : 32'd1);
    next();
    @(negedge clk);
    check_eq("rd_ack_wait", {31'd0, cpu_ack}, 32'd0);
    next();
    @(negedge clk);
    check_eq("rd_ack", {31'd0, cpu_ack}, 32'd1);
    next();
    cpu_req = 1'b0;
    next();
    check_eq("rd_vram100", {24'd0, vram[100]}, READ_EN ? 32'h77 : 32'h5A);

    // Back-to-back writes with the request held high
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'd200; cpu_wdata = 8'h11;
    rd_q.push_back(last_rd);
    rd_q.push_back(last_rd);
    for (int i = 0; i < 6; i++) begin
      if (i == 3) begin
        cpu_addr = 16'd201; cpu_wdata = 8'h22;
      end
      @(negedge clk);
      check_eq("b2b_we",  {31'd0, mem_we}, (i == 0 || i == 3) ? 32'd1 : 32'd0);
      check_eq("b2b_ack", {31'd0, cpu_ack}, (i == 2 || i == 5) ? 32'd1 : 32'd0);
      if (i == 3) check_eq("b2b_addr2", {16'd0, mem_addr}, 32'd201);
      next();
    end
    cpu_req = 1'b0;
    next();
    check_eq("b2b_vram200", {24'd0, vram[200]}, 32'h11);
    check_eq("b2b_vram201", {24'd0, vram[201]}, 32'h22);

    // Reset while the CPU access is in WAIT
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'd300; cpu_wdata = 8'h99;
    @(negedge clk);
    check_eq("rmo_issue_we", {31'd0, mem_we}, 32'd1);
    next();
    rst = 1'b1; cpu_req = 1'b0;
    @(negedge clk);
    check_eq("rmo_rst_we",   {31'd0, mem_we}, 32'd0);
    check_eq("rmo_rst_addr", {16'd0, mem_addr}, 32'd0);
    next();
    rst = 1'b0;
    @(negedge clk);
    check_eq("rmo_no_ack", {31'd0, cpu_ack}, 32'd0);
    check_eq("rmo_pixel",  {31'd0, pixel}, 32'd0);
    next();
    cpu_req = 1'b1; cpu_addr = 16'd301; cpu_wdata = 8'h44;
    rd_q.push_back(8'h00);
    @(negedge clk);
    check_eq("rmo_idle_issue", {31'd0, mem_we}, 32'd1);
    next();
    @(negedge clk);
    check_eq("rmo_ack_wait", {31'd0, cpu_ack}, 32'd0);
    next();
    @(negedge clk);
    check_eq("rmo_ack", {31'd0, cpu_ack}, 32'd1);
    next();
    cpu_req = 1'b0;
    next();
    check_eq("rmo_vram300", {24'd0, vram[300]}, 32'h99);
    check_eq("rmo_vram301", {24'd0, vram[301]}, 32'h44);

    // Address wrap over a whole (short) frame
    frame_start = 1'b1;
    @(negedge clk);
    check_eq("wrap_fs_addr", {16'd0, mem_addr}, 32'd0);
    next();
    frame_start = 1'b0;
    next();
    next();
    next();
    k = 0;
    for (int i = 0; i < FW * 8; i++) begin
      rgb_en = 1'b1;
      if (i % 8 == 1) begin
        k++;
        @(negedge clk);
        check_eq("wrap_addr", {16'd0, mem_addr}, 32'(k % FW));
        check_eq("wrap_we",   {31'd0, mem_we}, 32'd0);
        if (k == FW) check_eq("wrap_last_zero", {16'd0, mem_addr}, 32'd0);
      end
      next();
    end
    rgb_en = 1'b0;
    next();
    next();
    next();

    check_eq("pix_queue_empty", 32'(pix_q.size()), 32'd0);
    check_eq("ack_queue_empty", 32'(rd_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
